control_temp: RTL and testbench

CONTROL_TEMP -- requirements
Module: control_temp

---
 rtl/control_temp.sv | 172 +++++++++++++++++
 tb/tb_control_temp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_temp.sv
// -----------------------------------------------------------------------------
// control_temp -- periodic temperature sampler with confirmed level changes
//
// Every PERIODO cycles the controller asks the sensor for one reading
// (lectura_req) and waits up to TIMEOUT cycles for lectura_ack. An accepted
// reading is latched into temp_reg and classified into a target level
// (NORMAL / VENT / ALARMA). The level only changes after CONFIRM consecutive
// samples agree on the same new target. A missing acknowledge drives the
// block into FALLA immediately; the next good reading leaves FALLA directly.
//
// Optional build macro:
//   HISTERESIS_EN  -- lowers the exit thresholds (ALARMA held while temp>26,
//                     VENT held while temp>23); entry thresholds unchanged.
//
// Parameters:
//   PERIODO  cycles between sample requests      (2..65535)
//   CONFIRM  consecutive samples to change level (1..7)
//   TIMEOUT  cycles to wait for lectura_ack       (1..255)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   lectura_req  out  request one reading from the sensor
//   lectura_ack  in   sensor acknowledge, temp_in valid in the same cycle
//   temp_in      in   [4:0] unsigned reading in degrees
//   temp_reg     out  [4:0] last accepted reading
//   muestra_ok   out  one-cycle pulse after a reading is accepted
//   ventilador   out  fan enable (VENT, ALARMA, FALLA)
//   alarma       out  alarm (ALARMA, FALLA)
//   falla        out  sensor timeout indicator
//   estado       out  [1:0] level: 00 NORMAL, 01 VENT, 10 ALARMA, 11 FALLA
// -----------------------------------------------------------------------------
module control_temp #(
    parameter int PERIODO = 1000,
    parameter int CONFIRM = 3,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       lectura_req,
    input  logic       lectura_ack,
    input  logic [4:0] temp_in,
    output logic [4:0] temp_reg,
    output logic       muestra_ok,
    output logic       ventilador,
    output logic       alarma,
    output logic       falla,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        VENT   = 2'b01,
        ALARMA = 2'b10,
        FALLA  = 2'b11
    } nivel_t;

    nivel_t      nivel_reg, nivel_next;
    nivel_t      pend_reg, pend_next;
    nivel_t      objetivo;
    logic [2:0]  conf_reg, conf_next;
    logic [2:0]  conf_inc;
    logic        falla_next;
    logic [15:0] cnt_reg;
    logic [7:0]  espera_reg;
    logic [4:0]  umbral_alarma;
    logic [4:0]  umbral_vent;
    logic        timeout_hit;

    assign estado      = nivel_reg;
    assign timeout_hit = lectura_req && !lectura_ack
                         && (espera_reg == 8'(TIMEOUT - 1));

    // Classification thresholds. With hysteresis, being in ALARMA also
    // applies the lowered VENT exit threshold, so a cool-down from ALARMA
    // settles in VENT until the reading drops to 23 or below.
    always_comb begin
`ifdef HISTERESIS_EN
        umbral_alarma = (nivel_reg == ALARMA) ? 5'd26 : 5'd28;
        umbral_vent   = (nivel_reg == ALARMA || nivel_reg == VENT) ? 5'd23 : 5'd25;
`else
        umbral_alarma = 5'd28;
        umbral_vent   = 5'd25;
`endif
        if (temp_in > umbral_alarma)
            objetivo = ALARMA;
        else if (temp_in > umbral_vent)
            objetivo = VENT;
        else
            objetivo = NORMAL;
    end

    // Level / confirmation update. A cleared pending target reads as
    // NORMAL; if the level is not NORMAL and the target is NORMAL, the
    // "same as pending" path then yields a count of 1, exactly like a load.
    always_comb begin
        nivel_next = nivel_reg;
        pend_next  = pend_reg;
        conf_next  = conf_reg;
        falla_next = falla;
        conf_inc   = (objetivo == pend_reg) ? conf_reg + 3'd1 : 3'd1;
        if (lectura_req && lectura_ack) begin
            if (nivel_reg == FALLA) begin
                nivel_next = objetivo;
                falla_next = 1'b0;
                pend_next  = NORMAL;
                conf_next  = 3'd0;
            end else if (objetivo == nivel_reg) begin
                pend_next = NORMAL;
                conf_next = 3'd0;
            end else if (conf_inc == 3'(CONFIRM)) begin
                nivel_next = objetivo;
                pend_next  = NORMAL;
                conf_next  = 3'd0;
            end else begin
                pend_next = objetivo;
                conf_next = conf_inc;
            end
        end else if (timeout_hit) begin
            nivel_next = FALLA;
            falla_next = 1'b1;
            pend_next  = NORMAL;
            conf_next  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lectura_req <= 1'b0;
            muestra_ok  <= 1'b0;
            temp_reg    <= 5'd0;
            ventilador  <= 1'b0;
            alarma      <= 1'b0;
            falla       <= 1'b0;
            nivel_reg   <= NORMAL;
            pend_reg    <= NORMAL;
            conf_reg    <= 3'd0;
            cnt_reg     <= 16'd0;
            espera_reg  <= 8'd0;
        end else begin
            muestra_ok <= 1'b0;
            if (!lectura_req) begin
                // Period counter only runs between requests.
                espera_reg <= 8'd0;
                if (cnt_reg == 16'(PERIODO - 1)) begin
                    cnt_reg     <= 16'd0;
                    lectura_req <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end else if (lectura_ack) begin
                lectura_req <= 1'b0;
                temp_reg    <= temp_in;
                muestra_ok  <= 1'b1;
                espera_reg  <= 8'd0;
            end else if (timeout_hit) begin
                lectura_req <= 1'b0;
                espera_reg  <= 8'd0;
            end else begin
                espera_reg <= espera_reg + 8'd1;
            end

            nivel_reg  <= nivel_next;
            pend_reg   <= pend_next;
            conf_reg   <= conf_next;
            falla      <= falla_next;
            ventilador <= (nivel_next != NORMAL);
            alarma     <= (nivel_next == ALARMA) || (nivel_next == FALLA);
        end
    end

endmodule

// File: tb/tb_control_temp.sv
module tb_control_temp;

    localparam int P  = 4;
    localparam int CF = 3;
    localparam int TO = 8;

    logic       clk;
    logic       rst_n;
    logic       lectura_req;
    logic       lectura_ack;
    logic [4:0] temp_in;
    logic [4:0] temp_reg;
    logic       muestra_ok;
    logic       ventilador;
    logic       alarma;
    logic       falla;
    logic [1:0] estado;

    control_temp #(.PERIODO(P), .CONFIRM(CF), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lectura_req(lectura_req),
        .lectura_ack(lectura_ack),
        .temp_in    (temp_in),
        .temp_reg   (temp_reg),
        .muestra_ok (muestra_ok),
        .ventilador (ventilador),
        .alarma     (alarma),
        .falla      (falla),
        .estado     (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Level is an integer 0..3; q holds the run of identical non-current
    // targets seen since the last clear. A run of CF equal targets wins.
    int m_lvl  = 0;
    int m_treg = 0;
    int m_q[$];

    function automatic int m_target(input int t, input int lvl);
        int ua = 28;
        int uv = 25;
`ifdef HISTERESIS_EN
        if (lvl == 2) begin ua = 26; uv = 23; end
        else if (lvl == 1) uv = 23;
`endif
        if (t > ua) return 2;
        if (t > uv) return 1;
        return 0;
    endfunction

    task automatic model_sample(input int t);
        int tg;
        m_treg = t;
        tg = m_target(t, m_lvl);
        if (m_lvl == 3) begin
            m_lvl = tg;
            m_q.delete();
        end else if (tg == m_lvl) begin
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && m_q[$] != tg) m_q.delete();
            m_q.push_back(tg);
            if (m_q.size() == CF) begin
                m_lvl = tg;
                m_q.delete();
            end
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    int   edges_since = 0;  // edges since the last request ended / reset
    int   o_gap;
    logic o_to, o_mok, o_mok2, o_req, o_ven, o_ala, o_fal;
    logic [4:0] o_treg;
    logic [1:0] o_est;

    task automatic wait_req(output int n, output logic to);
        n = 0;
        while (!lectura_req && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        to = !lectura_req;
    endtask

    task automatic run_sample(input logic [4:0] t, input int dly);
        int n;
        wait_req(n, o_to);
        o_gap = edges_since + n;
        repeat (dly) begin @(posedge clk); #1; end
        lectura_ack = 1'b1;
        temp_in     = t;
        @(posedge clk); #1;
        lectura_ack = 1'b0;
        temp_in     = 5'($urandom);
        o_mok  = muestra_ok;
        o_treg = temp_reg;
        o_req  = lectura_req;
        o_est  = estado;
        o_ven  = ventilador;
        o_ala  = alarma;
        o_fal  = falla;
        @(posedge clk); #1;
        o_mok2 = muestra_ok;
        edges_since = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; lectura_ack = 1'b0; temp_in = 5'd0;
        #1;
        total++;
        if ({lectura_req, muestra_ok, temp_reg, ventilador, alarma, falla, estado} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {lectura_req, muestra_ok, temp_reg, ventilador, alarma, falla, estado});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        edges_since = 0;
        m_lvl = 0; m_treg = 0; m_q.delete();
    endtask

    task automatic test_levels;
        int seq[$] = '{20, 20, 22, 18,              // stays NORMAL
                       27, 27, 27,                  // -> VENT
                       20, 20, 20,                  // -> NORMAL
                       27, 20, 27, 20,              // no change
                       27, 30, 30, 30,              // pending reload -> ALARMA
                       24, 24, 24};                 // exit ALARMA
        for (int i = 0; i < 30; i++) seq.push_back($urandom_range(15, 31));
        for (int i = 0; i < seq.size(); i++) begin
            run_sample(5'(seq[i]), $urandom_range(0, 3));
            model_sample(seq[i]);
            total++;
            if (o_to || o_gap !== P) begin
                bad++;
                $display("FAIL req_spacing[%0d]: got %0d edges (timeout=%0d) want %0d", i, o_gap, o_to, P);
            end
            total++;
            if (o_mok !== 1'b1 || o_mok2 !== 1'b0) begin
                bad++;
                $display("FAIL muestra_ok_pulse[%0d]: got %b%b want 10", i, o_mok, o_mok2);
            end
            total++;
            if (o_treg !== 5'(m_treg) || o_req !== 1'b0) begin
                bad++;
                $display("FAIL temp_reg[%0d]: got %0d req=%b want %0d req=0", i, o_treg, o_req, m_treg);
            end
            total++;
            if (o_est !== 2'(m_lvl)) begin
                bad++;
                $display("FAIL estado[%0d] temp=%0d: got %0d want %0d", i, seq[i], o_est, m_lvl);
            end
            total++;
            if (o_ven !== (m_lvl != 0) || o_ala !== (m_lvl >= 2) || o_fal !== 1'b0) begin
                bad++;
                $display("FAIL flags[%0d]: got ven=%b ala=%b fal=%b want ven=%0d ala=%0d fal=0",
                         i, o_ven, o_ala, o_fal, m_lvl != 0, m_lvl >= 2);
            end
        end
    endtask

    task automatic test_ignore_ack;
        logic [1:0] est_before;
        est_before = estado;
        lectura_ack = 1'b1;
        temp_in     = 5'd31;
        @(posedge clk); #1;
        lectura_ack = 1'b0;
        edges_since++;
        total++;
        if (muestra_ok !== 1'b0 || temp_reg !== 5'(m_treg) || estado !== est_before) begin
            bad++;
            $display("FAIL ignore_ack: got mok=%b treg=%0d est=%0d want mok=0 treg=%0d est=%0d",
                     muestra_ok, temp_reg, estado, m_treg, est_before);
        end
    endtask

    task automatic test_timeout;
        int   n;
        logic to;
        wait_req(n, to);
        total++;
        if (to || edges_since + n !== P) begin
            bad++;
            $display("FAIL timeout_req_spacing: got %0d want %0d", edges_since + n, P);
        end
        repeat (TO - 1) begin @(posedge clk); #1; end
        total++;
        if (falla !== 1'b0 || lectura_req !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got falla=%b req=%b want falla=0 req=1", falla, lectura_req);
        end
        @(posedge clk); #1;
        m_lvl = 3; m_q.delete();
        edges_since = 0;
        total++;
        if (falla !== 1'b1 || estado !== 2'b11 || alarma !== 1'b1 || ventilador !== 1'b1
            || lectura_req !== 1'b0 || muestra_ok !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fault: got falla=%b est=%0d ala=%b ven=%b req=%b mok=%b want 1 3 1 1 0 0",
                     falla, estado, alarma, ventilador, lectura_req, muestra_ok);
        end
        run_sample(5'd20, 1);
        model_sample(20);
        total++;
        if (o_to || o_gap !== P || o_est !== 2'(m_lvl) || o_fal !== 1'b0 || o_ala !== 1'b0
            || o_ven !== 1'b0 || o_treg !== 5'd20) begin
            bad++;
            $display("FAIL fault_recover: got gap=%0d est=%0d fal=%b ala=%b ven=%b treg=%0d want %0d %0d 0 0 0 20",
                     o_gap, o_est, o_fal, o_ala, o_ven, o_treg, P, m_lvl);
        end
    endtask

    task automatic test_reset_mid_request;
        int   n;
        logic to;
        for (int i = 0; i < 3; i++) begin
            run_sample(5'd30, $urandom_range(0, 3));
            model_sample(30);
        end
        total++;
        if (o_est !== 2'b10 || o_ala !== 1'b1 || o_ven !== 1'b1 || m_lvl != 2) begin
            bad++;
            $display("FAIL enter_alarma: got est=%0d ala=%b ven=%b want 2 1 1", o_est, o_ala, o_ven);
        end
        wait_req(n, to);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (to || {lectura_req, muestra_ok, temp_reg, ventilador, alarma, falla, estado} !== 12'd0) begin
            bad++;
            $display("FAIL async_reset: got %b (req_seen=%b) want all zero",
                     {lectura_req, muestra_ok, temp_reg, ventilador, alarma, falla, estado}, !to);
        end
        m_lvl = 0; m_treg = 0; m_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lectura_ack = 1'b1;
        temp_in     = 5'd31;
        @(posedge clk); #1;
        lectura_ack = 1'b0;
        total++;
        if (muestra_ok !== 1'b0 || temp_reg !== 5'd0 || lectura_req !== 1'b0 || estado !== 2'b00) begin
            bad++;
            $display("FAIL late_ack: got mok=%b treg=%0d req=%b est=%0d want 0 0 0 0",
                     muestra_ok, temp_reg, lectura_req, estado);
        end
        edges_since = 1;
        run_sample(5'd20, 0);
        model_sample(20);
        total++;
        if (o_to || o_gap !== P || o_treg !== 5'd20 || o_est !== 2'(m_lvl)) begin
            bad++;
            $display("FAIL post_reset_sample: got gap=%0d treg=%0d est=%0d want %0d 20 %0d",
                     o_gap, o_treg, o_est, P, m_lvl);
        end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_ignore_ack();
        test_timeout();
        test_reset_mid_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
